box_painter: RTL and testbench
==============================

BOX_PAINTER -- requirements
Module: box_painter

Interface
REQ-001 Parameter BOX_W, default 64: box width in pixels.
REQ-002 Parameter BOX_H, default 24: box height in pixels.
REQ-003 Parameter SCR_W, default 640: screen width in pixels, used for clipping.
REQ-004 Parameter SCR_H, default 480: screen height in pixels, used for clipping.
REQ-005 CLOCK_50  in  1: single clock; all logic on its rising edge.
REQ-006 reset  in  1: synchronous, active-high reset.
REQ-007 start  in  1: request to paint one box; sampled only while busy=0.
REQ-008 x0  in  10: box top-left x, in pixels.
REQ-009 y0  in  9: box top-left y, in pixels.
REQ-010 color  in  9: fill colour, 3 bits per channel, RRRGGGBBB.
REQ-011 busy  out  1: high while a box is being painted.
REQ-012 done  out  1: one-cycle completion pulse.
REQ-013 pix_we  out  1: pixel-write valid.
REQ-014 pix_x  out  10: pixel x coordinate.
REQ-015 pix_y  out  9: pixel y coordinate.
REQ-016 pix_color  out  9: pixel colour.
REQ-017 pix_ready  in  1: frame buffer accepts the pixel this cycle.

Function
REQ-018 Three states SHALL exist: IDLE, DRAW and FIN.
- IDLE: busy=0, done=0.
- DRAW: busy=1.
- FIN: busy=0, done=1, lasting exactly one cycle.
REQ-019 When start=1 in IDLE or FIN, the block SHALL latch x0, y0 and color, clear the offsets (dx=0, dy=0) and enter DRAW on the next cycle.
REQ-020 start SHALL be ignored while in DRAW; the latched values SHALL remain unchanged.
REQ-021 In DRAW, pix_x SHALL equal x0+dx and pix_y SHALL equal y0+dy, computed with 11-bit and 10-bit sums respectively, with no wrap.
REQ-022 Pixels SHALL be emitted in raster order: dx from 0 to BOX_W-1 fastest, then dy from 0 to BOX_H-1.
REQ-023 pix_we SHALL be 1 in DRAW only when the current pixel lies on screen (pix_x < SCR_W and pix_y < SCR_H).
REQ-024 An on-screen pixel SHALL advance the offsets only on a cycle where pix_we=1 and pix_ready=1.
- pix_x, pix_y and pix_color SHALL hold steady while pix_ready=0.
REQ-025 An off-screen (clipped) pixel SHALL advance the offsets in one cycle with pix_we=0, independent of pix_ready.
REQ-026 Advancing the last pixel (dx=BOX_W-1, dy=BOX_H-1) SHALL move the block to FIN on the next cycle; FIN SHALL be followed by IDLE unless start is high.
REQ-027 With pix_ready held at 1 and no clipping:
- start sampled at cycle n gives first pix_we at n+1;
- done rises at n+1+BOX_W*BOX_H (n+1537 at the default parameters).
REQ-028 A box that is fully off screen SHALL complete in BOX_W*BOX_H cycles with pix_we never asserted.
REQ-029 pix_we SHALL be 0 in IDLE and FIN.

Reset
REQ-030 reset=1 SHALL force IDLE, including in the middle of a box; the aborted box SHALL produce no done pulse.
REQ-031 Reset values SHALL be: busy=0, done=0, pix_we=0, pix_x=0, pix_y=0, pix_color=0, dx=0, dy=0, latched registers=0.
REQ-032 A start asserted in the same cycle as reset SHALL be discarded.

Configuration
REQ-033 With BOX_PAINTER_BORDER_EN defined, pixels with dx=0, dx=BOX_W-1, dy=0 or dy=BOX_H-1 SHALL be written with colour 9'b000 (grid outline); interior pixels SHALL use the latched colour.
REQ-034 Without BOX_PAINTER_BORDER_EN, every pixel SHALL use the latched colour; pixel count and timing SHALL be identical in both builds.

Structure
REQ-035 A shared package tetris_pkg SHALL hold the following; the block's parameter defaults SHALL come from it:
- state encoding for IDLE, DRAW and FIN;
- colour width (9);
- SCR_W and SCR_H;
- the default cell size, 64x24.
REQ-036 One sub-module, box_scan_counter, SHALL hold the dx/dy raster counter, with inputs clear and advance and outputs dx, dy and last.

Verification
REQ-037 Scenario, basic fill: pix_ready=1, start with x0=64, y0=48, color=9'h1C7 -> exactly 1536 writes covering x 64..127 and y 48..71, done one cycle at start+1537, and busy=0 in that cycle.
REQ-038 Scenario, backpressure: pix_ready toggled randomly at 50% -> the same 1536 unique writes in raster order, no duplicate or lost pixel, and outputs stable while stalled.
REQ-039 Scenario, clipping: x0=608, y0=468 -> only x 608..639 by y 468..479 written (384 writes), with done still at start+1537 when pix_ready=1.
REQ-040 Scenario, back-to-back: start held through FIN with new x0=0 and y0=0 -> the second box begins the cycle after FIN, and the start seen mid-DRAW does not change the current box.
REQ-041 Scenario, reset mid-box: reset asserted after 100 writes -> the next cycle shows busy=0 and pix_we=0, no done pulse, and a fresh start paints correctly.
REQ-042 Scenario, BOX_PAINTER_BORDER_EN build with color=9'h1FF -> 172 writes with colour 9'h000 and 1364 writes with colour 9'h1FF.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris display blocks: FSM encoding, colour width,
// screen size and the default cell size used by box_painter.
package tetris_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int COLOR_W   = 9;
    localparam int SCR_W_DEF = 640;
    localparam int SCR_H_DEF = 480;
    localparam int CELL_W    = 64;
    localparam int CELL_H    = 24;

endpackage

// File: rtl/box_scan_counter.sv
// Raster offset counter for box_painter: dx runs fastest, dy steps on dx wrap.
module box_scan_counter #(
    parameter int BOX_W = 64,
    parameter int BOX_H = 24,
    parameter int DXW   = 6,
    parameter int DYW   = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    output logic [DXW-1:0] dx,
    output logic [DYW-1:0] dy,
    output logic           last
);

    localparam logic [DXW-1:0] DX_MAX = DXW'(BOX_W - 1);
    localparam logic [DYW-1:0] DY_MAX = DYW'(BOX_H - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            dx <= '0;
            dy <= '0;
        end else if (advance) begin
            if (dx == DX_MAX) begin
                dx <= '0;
                dy <= (dy == DY_MAX) ? '0 : dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

    assign last = (dx == DX_MAX) && (dy == DY_MAX);

endmodule

// File: rtl/box_painter.sv
// Paints a filled BOX_W x BOX_H rectangle into a frame buffer, one pixel per
// accepted write, clipping at the screen edge. Define BOX_PAINTER_BORDER_EN for a black outline.
module box_painter
    import tetris_pkg::*;
#(
    parameter int BOX_W = CELL_W,
    parameter int BOX_H = CELL_H,
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic [9:0]         x0,
    input  logic [8:0]         y0,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic               pix_we,
    output logic [9:0]         pix_x,
    output logic [8:0]         pix_y,
    output logic [COLOR_W-1:0] pix_color,
    input  logic               pix_ready
);

    localparam int DXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int DYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [10:0] SCR_W11 = 11'(SCR_W);
    localparam logic [9:0]  SCR_H10 = 10'(SCR_H);

    state_t             state, state_nx;
    logic [9:0]         x_q;
    logic [8:0]         y_q;
    logic [COLOR_W-1:0] c_q;
    logic [DXW-1:0]     dx;
    logic [DYW-1:0]     dy;
    logic               last, accept, advance, on_screen, edge_pix;
    logic [10:0]        sx;
    logic [9:0]         sy;

    assign accept = start && (state != ST_DRAW);

    // Widened sums so a box hanging past the edge is clipped, never wrapped.
    assign sx        = {1'b0, x_q} + 11'(dx);
    assign sy        = {1'b0, y_q} + 10'(dy);
    assign on_screen = (sx < SCR_W11) && (sy < SCR_H10);
    assign advance   = (state == ST_DRAW) && (!on_screen || pix_ready);

    box_scan_counter #(.BOX_W(BOX_W), .BOX_H(BOX_H), .DXW(DXW), .DYW(DYW)) u_scan (
        .clk     (CLOCK_50),
        .reset   (reset),
        .clear   (accept),
        .advance (advance),
        .dx      (dx),
        .dy      (dy),
        .last    (last)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            c_q <= '0;
        end else if (accept) begin
            x_q <= x0;
            y_q <= y0;
            c_q <= color;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_DRAW;
            ST_DRAW: if (advance && last) state_nx = ST_FIN;
            ST_FIN:  state_nx = accept ? ST_DRAW : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef BOX_PAINTER_BORDER_EN
    assign edge_pix = (dx == '0) || (dx == DXW'(BOX_W - 1)) ||
                      (dy == '0) || (dy == DYW'(BOX_H - 1));
`else
    assign edge_pix = 1'b0;
`endif

    always_comb begin
        busy      = (state == ST_DRAW);
        done      = (state == ST_FIN);
        pix_we    = (state == ST_DRAW) && on_screen;
        pix_x     = sx[9:0];
        pix_y     = sy[8:0];
        pix_color = edge_pix ? '0 : c_q;
    end

endmodule

// File: tb/tb_box_painter.sv
// Scoreboard bench for box_painter: stimulus pushes expected pixels, a negedge
// monitor pops and compares every accepted write.
module tb_box_painter;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] x0 = '0;
    logic [8:0] y0 = '0;
    logic [8:0] color = '0;
    logic       pix_ready = 1'b1;
    logic       busy, done, pix_we;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [8:0] pix_color;

    box_painter dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .color     (color),
        .busy      (busy),
        .done      (done),
        .pix_we    (pix_we),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .pix_ready (pix_ready)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int          cyc = 0;
    int          n_chk = 0, n_fail = 0;
    int          wr_cnt = 0, wr_black = 0, done_cnt = 0;
    bit          rnd_en = 1'b0;
    logic [27:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_box(input int x, input int y, input logic [8:0] c);
        for (int dy = 0; dy < 24; dy++)
            for (int dx = 0; dx < 64; dx++) begin
                int px = x + dx;
                int py = y + dy;
                logic [8:0] pc = c;
`ifdef BOX_PAINTER_BORDER_EN
                if (dx == 0 || dx == 63 || dy == 0 || dy == 23) pc = 9'h000;
`endif
                if (px < 640 && py < 480) exp_q.push_back({10'(px), 9'(py), pc});
            end
    endfunction

    initial forever begin
        @(posedge CLOCK_50);
        cyc++;
    end

    initial forever begin
        @(posedge CLOCK_50);
        #1;
        if (rnd_en) pix_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: every accepted write must match the head of the scoreboard.
    initial begin
        logic        stall_prev;
        logic [27:0] stall_val;
        stall_prev = 1'b0;
        stall_val  = '0;
        forever begin
            @(negedge CLOCK_50);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("stall_hold", {pix_we, pix_x, pix_y, pix_color}, {1'b1, stall_val});
                if (pix_we && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_write: got x=%0d y=%0d required none", pix_x, pix_y);
                    end else begin
                        check("pixel", {pix_x, pix_y, pix_color}, exp_q.pop_front());
                    end
                    wr_cnt++;
                    if (pix_color == 9'h000) wr_black++;
                end
                stall_prev = pix_we && !pix_ready;
                stall_val  = {pix_x, pix_y, pix_color};
                if (done) done_cnt++;
            end
        end
    end

    task automatic start_box(input int x, input int y, input logic [8:0] c, input bit hold,
                             output int k);
        @(posedge CLOCK_50);
        #1;
        x0 = 10'(x);
        y0 = 9'(y);
        color = c;
        start = 1'b1;
        k = cyc;
        push_box(x, y, c);
        @(posedge CLOCK_50);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cyc, input bit chk_t);
        bit got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge CLOCK_50);
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "_busy_at_done"}, 32'(busy), 32'd0);
            if (chk_t) check({name, "_done_cycle"}, cyc, exp_cyc);
        end
    endtask

    initial begin
        int k, w0, b0, d0, fin;
        bit hit;
        // Reset with start held high: start must be discarded.
        start = 1'b1; x0 = 10'd5; y0 = 9'd5; color = 9'h1FF;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_we", 32'(pix_we), 0);
        check("rst_outs", {pix_x, pix_y, pix_color}, 0);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge CLOCK_50);
            check("rst_start_dropped", 32'(busy), 0);
        end

        // Basic fill
        w0 = wr_cnt;
        start_box(64, 48, 9'h1C7, 1'b0, k);
        @(negedge CLOCK_50);
        check("basic_first", {busy, pix_we, pix_x, pix_y}, {1'b1, 1'b1, 10'd64, 9'd48});
        wait_done("basic", k + 1537, 1'b1);
        check("basic_writes", wr_cnt - w0, 1536);
        check("basic_q_empty", exp_q.size(), 0);

        // Backpressure
        w0 = wr_cnt;
        rnd_en = 1'b1;
        start_box(100, 200, 9'h038, 1'b0, k);
        wait_done("bp", 0, 1'b0);
        rnd_en = 1'b0;
        pix_ready = 1'b1;
        check("bp_writes", wr_cnt - w0, 1536);
        check("bp_q_empty", exp_q.size(), 0);

        // Clipping at bottom-right corner
        w0 = wr_cnt;
        start_box(608, 468, 9'h0F0, 1'b0, k);
        wait_done("clip", k + 1537, 1'b1);
        check("clip_writes", wr_cnt - w0, 384);
        check("clip_q_empty", exp_q.size(), 0);

        // Fully off screen
        w0 = wr_cnt;
        start_box(700, 10, 9'h00F, 1'b0, k);
        wait_done("offscr", k + 1537, 1'b1);
        check("offscr_writes", wr_cnt - w0, 0);

        // Back-to-back: start held through DRAW (ignored) and FIN (accepted)
        w0 = wr_cnt;
        start_box(10, 20, 9'h0AA, 1'b1, k);
        x0 = 10'd0; y0 = 9'd0; color = 9'h155;
        push_box(0, 0, 9'h155);
        wait_done("b2b_a", k + 1537, 1'b1);
        fin = cyc;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        @(negedge CLOCK_50);
        check("b2b_second_first", {busy, pix_we, pix_x, pix_y}, {1'b1, 1'b1, 10'd0, 9'd0});
        wait_done("b2b_b", fin + 1537, 1'b1);
        check("b2b_writes", wr_cnt - w0, 3072);
        check("b2b_q_empty", exp_q.size(), 0);

        // Reset in the middle of a box
        w0 = wr_cnt;
        d0 = done_cnt;
        start_box(200, 100, 9'h123, 1'b0, k);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge CLOCK_50);
            if (wr_cnt - w0 >= 100) hit = 1'b1;
        end
        check("midrst_reached_100", 32'(hit), 1);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("midrst_idle", {busy, pix_we, done}, 0);
        repeat (5) @(negedge CLOCK_50);
        check("midrst_no_done", done_cnt - d0, 0);

        // Fresh box touching the screen edge exactly, colour split by build
        w0 = wr_cnt;
        b0 = wr_black;
        start_box(576, 456, 9'h1FF, 1'b0, k);
        wait_done("edge", k + 1537, 1'b1);
        check("edge_writes", wr_cnt - w0, 1536);
        check("edge_q_empty", exp_q.size(), 0);
`ifdef BOX_PAINTER_BORDER_EN
        check("edge_black", wr_black - b0, 172);
        check("edge_fill", (wr_cnt - w0) - (wr_black - b0), 1364);
`else
        check("edge_black", wr_black - b0, 0);
        check("edge_fill", (wr_cnt - w0) - (wr_black - b0), 1536);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
